// File: rtl/aes_bist_ctrl_if.sv
// Host/wrapper-facing signal bundle of the AES BIST sequencer.
// Carries dbg_blocks only when AES_BIST_CTRL_DBG_EN is defined.
interface aes_bist_ctrl_if;
    logic       start;
    logic       abort;
    logic [7:0] d_out;
    logic       d_vld;
    logic       DONE;
    logic       is_bist;
    logic       en_lsfr_misr;
    logic       busy;
    logic       bist_done;
    logic       pass;
    logic       timeout;
    logic [7:0] sig;
`ifdef AES_BIST_CTRL_DBG_EN
    logic [7:0] dbg_blocks;

    modport slave (
        input  start, abort, d_out, d_vld, DONE,
        output is_bist, en_lsfr_misr, busy, bist_done, pass, timeout, sig, dbg_blocks
    );
    modport master (
        output start, abort, d_out, d_vld, DONE,
        input  is_bist, en_lsfr_misr, busy, bist_done, pass, timeout, sig, dbg_blocks
    );
`else
    modport slave (
        input  start, abort, d_out, d_vld, DONE,
        output is_bist, en_lsfr_misr, busy, bist_done, pass, timeout, sig
    );
    modport master (
        output start, abort, d_out, d_vld, DONE,
        input  is_bist, en_lsfr_misr, busy, bist_done, pass, timeout, sig
    );
`endif
endinterface

// File: rtl/aes_bist_ctrl.sv
// BIST sequencer for the 8-bit AES wrapper: settle, run LFSR/MISR, freeze, capture, compare.
// Optional DONE-edge block counter enabled by defining AES_BIST_CTRL_DBG_EN.
module aes_bist_ctrl #(
    parameter logic [7:0]  GOLDEN_SIG = 8'hC0,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned NUM_BLOCKS = 1,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic           clk,
    input  logic           rst,
    aes_bist_ctrl_if.slave bus
);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [11:0] BYTE_TARGET = 12'(16 * NUM_BLOCKS);
    localparam logic [15:0] GAP_LIMIT   = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_RUN,
        S_FREEZE,
        S_CAPTURE,
        S_RESULT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_settle_cnt, w_settle_cnt_nxt;
    logic [11:0] r_byte_cnt, w_byte_cnt_nxt, w_byte_inc;
    logic [15:0] r_gap_cnt, w_gap_cnt_nxt, w_gap_inc;
    logic        r_is_bist, w_is_bist_nxt;
    logic        r_en, w_en_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_bist_done, w_bist_done_nxt;
    logic        r_pass, w_pass_nxt;
    logic        r_timeout, w_timeout_nxt;
    logic [7:0]  r_sig, w_sig_nxt;
    logic        w_sig_match;

`ifdef AES_BIST_CTRL_DBG_EN
    logic [7:0]  r_dbg_blocks, w_dbg_blocks_nxt;
    logic        r_done_d;
    assign w_sig_match = (bus.d_out == GOLDEN_SIG) && (r_dbg_blocks == 8'(NUM_BLOCKS));
`else
    logic        w_unused_done;
    assign w_unused_done = bus.DONE;
    assign w_sig_match   = (bus.d_out == GOLDEN_SIG);
`endif

    assign w_byte_inc = (r_byte_cnt == '1) ? r_byte_cnt : r_byte_cnt + 12'd1;
    assign w_gap_inc  = (r_gap_cnt == '1)  ? r_gap_cnt  : r_gap_cnt + 16'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_pass_nxt       = r_pass;
        w_timeout_nxt    = r_timeout;
        w_sig_nxt        = r_sig;
`ifdef AES_BIST_CTRL_DBG_EN
        w_dbg_blocks_nxt = r_dbg_blocks;
`endif

        case (r_state)
            S_IDLE, S_RESULT: begin
                if (bus.start) begin
                    w_state_nxt      = S_SETTLE;
                    w_settle_cnt_nxt = '0;
                    w_byte_cnt_nxt   = '0;
                    w_gap_cnt_nxt    = '0;
                    w_pass_nxt       = 1'b0;
                    w_timeout_nxt    = 1'b0;
                    w_sig_nxt        = '0;
`ifdef AES_BIST_CTRL_DBG_EN
                    w_dbg_blocks_nxt = '0;
`endif
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt >= SETTLE_LAST) w_state_nxt = S_RUN;
                else                             w_settle_cnt_nxt = r_settle_cnt + 8'd1;
            end
            S_RUN: begin
`ifdef AES_BIST_CTRL_DBG_EN
                if (bus.DONE && !r_done_d && (r_dbg_blocks != '1))
                    w_dbg_blocks_nxt = r_dbg_blocks + 8'd1;
`endif
                // A byte arriving on the expiry cycle wins over the timeout.
                if (bus.d_vld) begin
                    w_byte_cnt_nxt = w_byte_inc;
                    w_gap_cnt_nxt  = '0;
                    if (w_byte_inc >= BYTE_TARGET) w_state_nxt = S_FREEZE;
                end else begin
                    w_gap_cnt_nxt = w_gap_inc;
                    if (w_gap_inc >= GAP_LIMIT) begin
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = S_FREEZE;
                    end
                end
            end
            S_FREEZE: w_state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                w_sig_nxt   = bus.d_out;
                w_pass_nxt  = w_sig_match && !r_timeout;
                w_state_nxt = S_RESULT;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (bus.abort) begin
            w_state_nxt      = S_IDLE;
            w_settle_cnt_nxt = '0;
            w_byte_cnt_nxt   = '0;
            w_gap_cnt_nxt    = '0;
            w_pass_nxt       = 1'b0;
            w_timeout_nxt    = 1'b0;
            w_sig_nxt        = '0;
`ifdef AES_BIST_CTRL_DBG_EN
            w_dbg_blocks_nxt = '0;
`endif
        end

        // Output flags are decoded from the next state so they register alongside it.
        w_busy_nxt      = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_RUN) ||
                          (w_state_nxt == S_FREEZE) || (w_state_nxt == S_CAPTURE);
        w_is_bist_nxt   = w_busy_nxt;
        w_en_nxt        = (w_state_nxt == S_RUN);
        w_bist_done_nxt = (w_state_nxt == S_RESULT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_byte_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_is_bist    <= 1'b0;
            r_en         <= 1'b0;
            r_busy       <= 1'b0;
            r_bist_done  <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_sig        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_is_bist    <= w_is_bist_nxt;
            r_en         <= w_en_nxt;
            r_busy       <= w_busy_nxt;
            r_bist_done  <= w_bist_done_nxt;
            r_pass       <= w_pass_nxt;
            r_timeout    <= w_timeout_nxt;
            r_sig        <= w_sig_nxt;
        end
    end

`ifdef AES_BIST_CTRL_DBG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dbg_blocks <= '0;
            r_done_d     <= 1'b0;
        end else begin
            r_dbg_blocks <= w_dbg_blocks_nxt;
            r_done_d     <= bus.DONE;
        end
    end

    assign bus.dbg_blocks = r_dbg_blocks;
`endif

    assign bus.is_bist      = r_is_bist;
    assign bus.en_lsfr_misr = r_en;
    assign bus.busy         = r_busy;
    assign bus.bist_done    = r_bist_done;
    assign bus.pass         = r_pass;
    assign bus.timeout      = r_timeout;
    assign bus.sig          = r_sig;

endmodule
